// File: rtl/acc_int_add_pkg.sv
// Shared constants for the registered integer adder.
package acc_int_add_pkg;

  localparam int CLA_W               = 4;
  localparam int DEFAULT_OP_BITWIDTH = 32;

endpackage

// File: rtl/acc_int_add_cla4.sv
// 4-bit carry-lookahead group: purely combinational, no state, no flow control.
module acc_int_add_cla4
  import acc_int_add_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic [CLA_W-1:0] s,
  output logic             cout
);

  logic [CLA_W-1:0] g;
  logic [CLA_W-1:0] p;
  logic [CLA_W-1:0] cy;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is expanded from cin directly rather than rippled.
  assign cy[0] = cin;
  assign cy[1] = g[0] | (p[0] & cin);
  assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
  assign cout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ cy;

endmodule

// File: rtl/acc_int_add.sv
// Registered modular adder c = (a + b) mod 2^OP_BITWIDTH built from chained CLA groups.
// Latency 1 cycle, one result per cycle; no handshake, inputs consumed every cycle.
module acc_int_add
  import acc_int_add_pkg::*;
#(
  parameter int OP_BITWIDTH = DEFAULT_OP_BITWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_BITWIDTH-1:0] a,
  input  logic [OP_BITWIDTH-1:0] b,
  output logic [OP_BITWIDTH-1:0] c
);

  localparam int NG = (OP_BITWIDTH + CLA_W - 1) / CLA_W;
  localparam int PW = NG * CLA_W;

  logic [PW-1:0]          a_pad;
  logic [PW-1:0]          b_pad;
  logic [PW-1:0]          s_pad;
  logic [NG:0]            carry;
  logic [OP_BITWIDTH-1:0] c_d;
  logic [OP_BITWIDTH-1:0] c_q;

  // Zero padding keeps the spare top lanes defined; their sum bits are dropped.
  assign a_pad    = PW'(a);
  assign b_pad    = PW'(b);
  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < NG; gi++) begin : g_cla
    acc_int_add_cla4 u_cla4 (
      .a    (a_pad[gi*CLA_W +: CLA_W]),
      .b    (b_pad[gi*CLA_W +: CLA_W]),
      .cin  (carry[gi]),
      .s    (s_pad[gi*CLA_W +: CLA_W]),
      .cout (carry[gi+1])
    );
  end

  assign c_d = s_pad[OP_BITWIDTH-1:0];

  // Final carry-out and padded sum lanes are intentionally discarded.
  logic          unused_carry;
  logic [PW-1:0] unused_pad;
  assign unused_carry = carry[NG];
  assign unused_pad   = s_pad;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_acc_int_add.sv
// Scoreboard bench for acc_int_add at OP_BITWIDTH 32 and 6 sharing clock and reset.
module tb_acc_int_add;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] c32;
  logic [5:0]  a6 = '0, b6 = '0;
  logic [5:0]  c6;

  logic [31:0] q32[$];
  logic [5:0]  q6[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acc_int_add #(.OP_BITWIDTH(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .a   (a32),
    .b   (b32),
    .c   (c32)
  );

  acc_int_add #(.OP_BITWIDTH(6)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .a   (a6),
    .b   (b6),
    .c   (c6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected result, compare after the edge.
  task automatic step(input string tag, input logic r,
                      input logic [31:0] x32, input logic [31:0] y32,
                      input logic [5:0] x6, input logic [5:0] y6);
    logic [63:0] sum;
    rst = r;
    a32 = x32; b32 = y32;
    a6  = x6;  b6  = y6;
    sum = 64'(x32) + 64'(y32);
    q32.push_back(r ? 32'h0 : sum[31:0]);
    sum = (64'(x6) + 64'(y6)) % 64;
    q6.push_back(r ? 6'h0 : sum[5:0]);
    @(posedge clk);
    #1;
    if (q32.size() == 0 || q6.size() == 0) begin
      chk({tag, "/empty"}, 64'(q32.size() + q6.size()), 64'd2);
    end else begin
      chk({tag, "/w32"}, 64'(c32), 64'(q32.pop_front()));
      chk({tag, "/w6"},  64'(c6),  64'(q6.pop_front()));
    end
  endtask

  initial begin
    #1;
    step("rst0", 1'b1, 32'h1234, 32'h1111, 6'h12, 6'h11);
    step("rst1", 1'b1, 32'h1234, 32'h1111, 6'h2a, 6'h15);
    step("post_rst", 1'b0, 32'h0, 32'h0, 6'h0, 6'h0);

    step("basic",   1'b0, 32'h0000_0005, 32'h0000_0003, 6'h05, 6'h03);
    step("wrap1",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 6'h3F, 6'h01);
    step("wrap2",   1'b0, 32'h8000_0000, 32'h8000_0000, 6'h20, 6'h20);
    step("chain",   1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 6'h1F, 6'h01);
    step("grp_bnd", 1'b0, 32'h0000_000F, 32'h0000_0001, 6'h0F, 6'h01);
    step("neg",     1'b0, 32'hFFFF_FFFE, 32'h0000_0005, 6'h3E, 6'h05);

    step("strm1",   1'b0, 32'd1, 32'd2, 6'd1, 6'd2);
    step("strm2",   1'b0, 32'd3, 32'd4, 6'd3, 6'd4);
    step("strm3",   1'b0, 32'd5, 32'd6, 6'd5, 6'd6);
    step("mid_rst", 1'b1, 32'd7, 32'd8, 6'd7, 6'd8);
    step("resume",  1'b0, 32'h0000_1000, 32'h0000_0234, 6'h10, 6'h23);

    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'b0, $urandom, $urandom, 6'($urandom), 6'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
